// File: rtl/g25_hex_pkg.sv
// g25_hex_pkg: shared states, PIO selects and seven-segment codes for the HEX scroller.
package g25_hex_pkg;
  typedef enum logic [2:0] {IDLE, WR2, WR1, WR0, WAIT} state_t;
  localparam logic [2:0] HEX54 = 3'b100;
  localparam logic [2:0] HEX32 = 3'b010;
  localparam logic [2:0] HEX10 = 3'b001;
  localparam logic [7:0] BLANK = 8'hFF;
  function automatic logic [7:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction
endpackage

// File: rtl/g25_hex7seg_enc.sv
// g25_hex7seg_enc: nibble to active-low seven-segment code with DP off.
module g25_hex7seg_enc
  import g25_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] code
);
  assign code = hex_code(nibble);
endmodule

// File: rtl/g25_hex_scroll_ctrl.sv
// g25_hex_scroll_ctrl: latches a digest and scrolls its 64 nibbles over HEX5..HEX0
// through three Avalon-MM writes per step.
module g25_hex_scroll_ctrl
  import g25_hex_pkg::*;
#(
  parameter int DIGEST_W = 256,
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                digest_valid,
  input  logic [DIGEST_W-1:0] digest,
  output logic                digest_ready,
  input  logic                enable,
  output logic [1:0]          avm_address,
  output logic [2:0]          avm_chipselect,
  output logic                avm_write_n,
  output logic [31:0]         avm_writedata,
  output logic [5:0]          position
);
  localparam logic [31:0] TC = 32'(TICKS_PER_STEP - 1);
  state_t state_q, state_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic [5:0] position_q, position_d, off, idx_l, idx_r;
  logic [31:0] tick_q, tick_d, wdata_q, wdata_d;
  logic [2:0] cs_q, cs_d;
  logic ready_q, ready_d, write_n_q, wr, take;
  logic [3:0] nib_l, nib_r;
  logic [7:0] code_l, code_r;
  assign take = digest_valid & ready_q;
  always_comb begin
    state_d = state_q;
    digest_d = digest_q;
    position_d = position_q;
    tick_d = tick_q;
    if (take) begin
      state_d = WR2;
      digest_d = digest;
      position_d = 6'd0;
      tick_d = 32'd0;
    end else if (state_q == WR2) begin
      state_d = WR1;
    end else if (state_q == WR1) begin
      state_d = WR0;
    end else if (state_q == WR0) begin
      state_d = WAIT;
    end else if (state_q == WAIT && enable) begin
      state_d = (tick_q == TC) ? WR2 : WAIT;
      position_d = (tick_q == TC) ? position_q + 6'd1 : position_q;
      tick_d = (tick_q == TC) ? 32'd0 : tick_q + 32'd1;
    end
  end
  // Outputs are precomputed from the next state so the registers show the current write.
  assign wr = (state_d == WR2) | (state_d == WR1) | (state_d == WR0);
  assign cs_d = (state_d == WR2) ? HEX54 : (state_d == WR1) ? HEX32 : (state_d == WR0) ? HEX10 : 3'b000;
  assign off = (state_d == WR1) ? 6'd2 : (state_d == WR0) ? 6'd4 : 6'd0;
  assign idx_l = position_d + off;
  assign idx_r = idx_l + 6'd1;
  assign nib_l = digest_d[{~idx_l, 2'b00} +: 4];
  assign nib_r = digest_d[{~idx_r, 2'b00} +: 4];
  assign wdata_d = wr ? {16'h0000, code_l, code_r} : 32'h0;
  assign ready_d = (state_d == IDLE) | (state_d == WAIT);
  g25_hex7seg_enc u_enc_l (.nibble(nib_l), .code(code_l));
  g25_hex7seg_enc u_enc_r (.nibble(nib_r), .code(code_r));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      digest_q <= '0;
      position_q <= 6'd0;
      tick_q <= 32'd0;
      cs_q <= 3'b000;
      write_n_q <= 1'b1;
      wdata_q <= 32'h0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      digest_q <= digest_d;
      position_q <= position_d;
      tick_q <= tick_d;
      cs_q <= cs_d;
      write_n_q <= ~wr;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
    end
  end
  assign avm_address = 2'b00;
  assign avm_chipselect = cs_q;
  assign avm_write_n = write_n_q;
  assign avm_writedata = wdata_q;
  assign digest_ready = ready_q;
  assign position = position_q;
endmodule
